// File: rtl/intersection_arbiter_if.sv
// Signal bundle between the intersection arbiter and its car sensors / signal heads.
// The arbiter sits on the slave side; the sensor/head side drives req.
interface intersection_arbiter_if;
    logic [3:0] req;
    logic [7:0] lights;
    logic [3:0] grant;
    logic [1:0] phase;

    modport master (
        output req,
        input  lights,
        input  grant,
        input  phase
    );

    modport slave (
        input  req,
        output lights,
        output grant,
        output phase
    );
endinterface

// File: rtl/intersection_arbiter.sv
// Round-robin right-of-way for a four-approach intersection.
// Approach 0 is home and rests green when nobody else calls.
module intersection_arbiter #(
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 10,
    parameter int YEL_TIME    = 3,
    parameter int ALLRED_TIME = 2,
    parameter int TW          = 8
) (
    input  logic                 clock,
    input  logic                 clear,
    intersection_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } state_t;

    localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_LAST = TW'(YEL_TIME - 1);
    localparam logic [TW-1:0] AR_LAST  = TW'(ALLRED_TIME - 1);

    state_t        state, state_n;
    logic [1:0]    cur, cur_n;
    logic [1:0]    winner;
    logic [TW-1:0] timer, timer_n;
    logic [TW-1:0] gcnt, gcnt_n;
    logic          other_req;
    logic          gap_out;
    logic          max_out;

    // Search starts just after the current holder; home wins an empty search.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        other_req = |(bus.req & ~(4'b0001 << cur));
        gap_out   = (gcnt >= MIN_LAST) && !bus.req[cur];
        max_out   = (gcnt >= MAX_LAST);
    end

    always_comb begin
        state_n = state;
        cur_n   = cur;
        timer_n = timer;
        gcnt_n  = gcnt;
        unique case (state)
            ALLRED: begin
                if (timer == '0) begin
                    cur_n   = winner;
                    gcnt_n  = '0;
                    state_n = GREEN;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            GREEN: begin
                if (gcnt < MAX_LAST) gcnt_n = gcnt + 1'b1;
                if (other_req && (gap_out || max_out)) begin
                    state_n = YELLOW;
                    timer_n = YEL_LAST;
                end
            end
            YELLOW: begin
                if (timer == '0) begin
                    state_n = ALLRED;
                    timer_n = AR_LAST;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: begin
                state_n = ALLRED;
                timer_n = AR_LAST;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= ALLRED;
            timer <= AR_LAST;
            cur   <= 2'd3;
            gcnt  <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            cur   <= cur_n;
            gcnt  <= gcnt_n;
        end
    end

    // Outputs decode from registers only, never from req.
    always_comb begin
        bus.lights = '0;
        bus.grant  = '0;
        bus.phase  = state;
        unique case (state)
            GREEN: begin
                bus.lights[{cur, 1'b0} +: 2] = 2'd2;
                bus.grant[cur]               = 1'b1;
            end
            YELLOW: begin
                bus.lights[{cur, 1'b0} +: 2] = 2'd1;
                bus.grant[cur]               = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intersection_arbiter.sv
// Directed bench for intersection_arbiter with hand-computed light sequences.
// Also watches every cycle that at most one approach is non-RED.
module tb_intersection_arbiter;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    intersection_arbiter_if bus ();

    intersection_arbiter #(
        .MIN_GREEN  (4),
        .MAX_GREEN  (10),
        .YEL_TIME   (3),
        .ALLRED_TIME(2),
        .TW         (8)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic look(input string tag, input logic [7:0] l,
                        input logic [3:0] g, input logic [1:0] p);
        check({tag, "_lights"}, 32'(bus.lights), 32'(l));
        check({tag, "_grant"}, 32'(bus.grant), 32'(g));
        check({tag, "_phase"}, 32'(bus.phase), 32'(p));
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] g,
                              input int budget);
        for (int i = 0; i < budget && bus.grant !== g; i++) tick();
        check(tag, 32'(bus.grant), 32'(g));
    endtask

    function automatic logic excl_ok(input logic [7:0] l);
        int n;
        logic [1:0] f;
        n = 0;
        excl_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f = l[2*i +: 2];
            if (f != 2'd0) n++;
            if (f == 2'd3) excl_ok = 1'b0;
        end
        if (n > 1) excl_ok = 1'b0;
    endfunction

    always @(negedge clock)
        if (!done) check("excl", 32'(excl_ok(bus.lights)), 32'd1);

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bus.req = 4'b0000;
        clear   = 1'b1;
        repeat (3) tick();
        look("rst", 8'h00, 4'b0000, 2'd0);

        // idle rest
        clear = 1'b0;
        look("idle_ar0", 8'h00, 4'b0000, 2'd0);
        tick();
        look("idle_ar1", 8'h00, 4'b0000, 2'd0);
        tick();
        look("idle_g", 8'h02, 4'b0001, 2'd1);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_hold", 32'(bus.lights), 32'h02);
        end

        // single call from approach 2
        bus.req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            look("call_y", 8'h01, 4'b0001, 2'd2);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            look("call_ar", 8'h00, 4'b0000, 2'd0);
        end
        tick();
        look("call_g", 8'h20, 4'b0100, 2'd1);

        // max-out on approach 1
        bus.req = 4'b0010;
        wait_grant("mx_enter", 4'b0010, 40);
        bus.req = 4'b1010;
        check("mx_g1", 32'(bus.phase), 32'd1);
        for (int i = 0; i < 9; i++) begin
            tick();
            look("mx_g", 8'h08, 4'b0010, 2'd1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            look("mx_y", 8'h04, 4'b0010, 2'd2);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            look("mx_ar", 8'h00, 4'b0000, 2'd0);
        end
        tick();
        look("mx_next", 8'h80, 4'b1000, 2'd1);

        // gap-out on approach 1
        bus.req = 4'b0010;
        wait_grant("gp_enter", 4'b0010, 40);
        bus.req = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            look("gp_g", 8'h08, 4'b0010, 2'd1);
        end
        tick();
        look("gp_y", 8'h04, 4'b0010, 2'd2);

        // round robin with everyone calling
        clear   = 1'b1;
        bus.req = 4'b1111;
        repeat (3) tick();
        look("rr_rst", 8'h00, 4'b0000, 2'd0);
        clear = 1'b0;
        tick();
        tick();
        for (int n = 0; n < 5; n++) begin
            logic [3:0] g;
            g = 4'b0001 << (n % 4);
            check("rr_first", 32'(bus.grant), 32'(g));
            check("rr_ph_g", 32'(bus.phase), 32'd1);
            repeat (9) tick();
            check("rr_last", 32'(bus.grant), 32'(g));
            check("rr_last_ph", 32'(bus.phase), 32'd1);
            tick();
            check("rr_yel", 32'(bus.phase), 32'd2);
            repeat (5) tick();
        end

        // reset on the second yellow cycle of approach 2
        wait_grant("ry_enter", 4'b0100, 40);
        repeat (10) tick();
        tick();
        look("ry_y2", 8'h10, 4'b0100, 2'd2);
        clear   = 1'b1;
        bus.req = 4'b0000;
        tick();
        look("ry_clr", 8'h00, 4'b0000, 2'd0);
        clear = 1'b0;
        tick();
        look("ry_ar", 8'h00, 4'b0000, 2'd0);
        tick();
        look("ry_home", 8'h02, 4'b0001, 2'd1);

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intersection_arbiter.md
# intersection_arbiter

- Shares one four-approach intersection among four car-sensor requesters.
- Grants right-of-way round-robin, one approach at a time, with cycle-counted minimum green, maximum green, yellow and all-red clearance intervals.
- Sits above the per-approach signal heads; approach 0 is the home (highway) approach and rests green when nobody else requests.
- All timing is synthesizable counters; there are no event-control delays.

## Interface

- `MIN_GREEN`, 4: minimum green cycles per grant (≥1).
- `MAX_GREEN`, 10: maximum green cycles when others wait (≥ MIN_GREEN).
- `YEL_TIME`, 3: yellow cycles (≥1).
- `ALLRED_TIME`, 2: all-red clearance cycles (≥1).
- `TW`, 8: timer width; every time parameter ≤ 2^TW−1.

- `clock`  in  1  system clock, all state on rising edge.
- `clear`  in  1  reset, synchronous, active-high.
- `req`  in  4  car present on approach i, level-sensitive.
- `lights`  out  8  bits [2i+1:2i] are approach i light: RED=2'd0, YELLOW=2'd1, GREEN=2'd2; 2'd3 never driven.
- `grant`  out  4  one-hot current approach during GREEN/YELLOW, else 0.
- `phase`  out  2  state: 0=ALLRED, 1=GREEN, 2=YELLOW.

## Operation

- **Registers:** `state`, `cur` (2b), `timer` (TW), `gcnt` (TW). Outputs decode from registers only; there is no combinational path from `req` to outputs.
- **Reset** (edge with `clear`=1):
  - state=ALLRED, timer=ALLRED_TIME−1, cur=3, gcnt=0.
  - Outputs: lights=8'h00, grant=0, phase=0.
- **ALLRED:**
  - Decrement timer each cycle.
  - When timer==0, pick winner by round-robin search of `req` starting at (cur+1) mod 4, wrapping.
  - If `req`==0, winner=0 (home).
  - Then cur=winner, gcnt=0, go GREEN.
  - Only cur requesting → cur is re-granted after clearance.
- **GREEN:**
  - lights[cur]=GREEN, others RED.
  - gcnt increments each cycle, saturating at MAX_GREEN−1.
  - other_req = |(req & ~onehot(cur)).
  - Exit to YELLOW (timer=YEL_TIME−1) when other_req AND either:
    - gap-out: gcnt ≥ MIN_GREEN−1 and req[cur]=0; or
    - max-out: gcnt ≥ MAX_GREEN−1.
  - No other_req → stay GREEN indefinitely.
- **YELLOW:**
  - lights[cur]=YELLOW.
  - Decrement timer; at timer==0 go ALLRED (timer=ALLRED_TIME−1).
  - Yellow is never aborted by `req` changes.
- **Invariant:** at most one approach is non-RED in any cycle.
- **Arithmetic:** unsigned; the timer never underflows because the state changes at 0.
- **Reset mid-operation:** `clear` overrides every state on the same edge, including mid-YELLOW and mid-GREEN. The light goes RED immediately; partial counts are discarded.

## Timing

- State lengths in cycles:
  - ALLRED: exactly ALLRED_TIME.
  - YELLOW: exactly YEL_TIME.
  - GREEN: ≥ MIN_GREEN when gap-out applies, ≤ MAX_GREEN whenever other_req holds continuously from green entry.
- **Request latency:** with cur green and gcnt saturated, a new other request sampled at edge t gives YELLOW visible after edge t.
- **Request that arrives and drops:** a request asserted and dropped while cur is GREEN and below MIN_GREEN−1 is not latched; `req` must be held.
- **Phase latency** from YELLOW entry to next GREEN: YEL_TIME + ALLRED_TIME cycles.
- **After `clear` deasserts:** ALLRED persists ALLRED_TIME cycles counted from the last edge with `clear`=1. The first winner search starts at approach 0.
- **Simultaneous requests:** resolved only by the round-robin order from cur+1. There is no fixed priority except that the home approach is the default.

## Test plan

Defaults for all scenarios: MIN_GREEN=4, MAX_GREEN=10, YEL_TIME=3, ALLRED_TIME=2.

1. **Idle rest:** `clear`=1 for 3 cycles, req=0 → lights=8'h00 for 2 cycles after release, then lights=8'h02, grant=4'b0001, phase=1, held 50 cycles.
2. **Single call:** from idle rest, req=4'b0100 held → next cycle lights=8'h01 for 3 cycles, then 8'h00 for 2 cycles, then lights=8'h20, grant=4'b0100.
3. **Max-out:** approach 1 enters GREEN with req=4'b1010 held → GREEN exactly 10 cycles, yellow 3, all-red 2, then grant=4'b1000.
4. **Gap-out:** approach 1 enters GREEN with req=4'b1000 (req[1]=0) → GREEN exactly 4 cycles, then YELLOW.
5. **Round-robin fairness:** req=4'b1111 held from reset → grants 0,1,2,3,0 in order, each GREEN 10 cycles, 15-cycle period per approach. Checker confirms at most one non-RED field every cycle.
6. **Reset mid-yellow:** assert `clear` on the 2nd YELLOW cycle of approach 2 → lights=8'h00 and grant=0 at that edge, then after release approach 0 GREEN (with req=0).
